// File: rtl/rom_seq_loader_pkg.sv
// rom_seq_loader_pkg
//   Shared definitions for the parameter-memory sequencer: default widths,
//   output buffer depth and the FSM state encoding.
package rom_seq_loader_pkg;

   localparam int DWIDTH_DEF = 32;
   localparam int AWIDTH_DEF = 8;
   localparam int CWIDTH_DEF = 9;
   localparam int BUF_DEPTH  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rom_seq_fifo2.sv
// rom_seq_fifo2
//   Two-entry FIFO holding {index, data} words read from parameter memory.
//   The caller never pushes when full, nor pops when empty.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i at the tail
//   pop_i      : drop the head entry
//   din_i      : entry to write
//   dout_o     : head entry (valid when occ_o != 0)
//   occ_o      : number of stored entries (0..2)
module rom_seq_fifo2 #(
   parameter int WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [1:0]       occ_o
);

   logic [WIDTH-1:0] ent0_q, ent1_q;
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       occ_q, occ_d;

   always_comb begin
      occ_d = occ_q;
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) begin
            if (wr_ptr_q) ent1_q <= din_i;
            else          ent0_q <= din_i;
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_d;
      end
   end

   assign dout_o = rd_ptr_q ? ent1_q : ent0_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/rom_seq_loader.sv
// rom_seq_loader
//   Reads a contiguous block (base, count) from the synchronous parameter
//   memory and streams the words, tagged with their offset, over valid/ready.
//   At most two words are ever outstanding (buffered + in flight), so
//   back-pressure can never overflow the 2-entry output buffer.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin transfer (sampled in IDLE only)
//   base_addr, word_count : block descriptor, captured on accepted start
//   busy, done            : transfer in progress / one-cycle completion pulse
//   mem_en, mem_addr      : memory read request
//   mem_rdata             : memory data, one cycle after mem_en
//   out_valid, out_ready  : output handshake
//   out_data, out_index   : word and its offset within the transfer
//   checksum              : sum of handed-off words (ROM_SEQ_CHECKSUM_EN only)
// Build option: define ROM_SEQ_CHECKSUM_EN to add the checksum output.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FETCH | issuing reads while buffer space allows
// ST_DRAIN | all reads issued, emptying buffer / in-flight word
// ST_DONE  | one-cycle done pulse, start ignored
module rom_seq_loader
   import rom_seq_loader_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int CWIDTH = CWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [CWIDTH-1:0] word_count,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
`ifdef ROM_SEQ_CHECKSUM_EN
   output logic [DWIDTH-1:0] checksum,
`endif
   output logic [AWIDTH-1:0] out_index
);

   state_t              state_q, state_d;
   logic [AWIDTH-1:0]   base_q, base_d;
   logic [CWIDTH-1:0]   count_q, count_d;
   logic [CWIDTH-1:0]   issue_q, issue_d;
   logic [CWIDTH-1:0]   issue_nxt;
   logic                inflight_q, inflight_d;
   logic [AWIDTH-1:0]   fl_idx_q, fl_idx_d;

   logic [1:0]          occ;
   logic [1:0]          pending;
   logic                buf_empty;
   logic [DWIDTH+AWIDTH-1:0] buf_dout;
   logic [DWIDTH-1:0]   head_data;
   logic [AWIDTH-1:0]   head_idx;
   logic                start_acc, issue, hs, push, pop;

   assign buf_empty = (occ == 2'd0);
   assign pending   = occ + {1'b0, inflight_q};
   assign head_data = buf_dout[DWIDTH-1:0];
   assign head_idx  = buf_dout[DWIDTH +: AWIDTH];
   assign issue_nxt = issue_q + CWIDTH'(1);

   assign start_acc = (state_q == ST_IDLE) && start;
   assign issue     = (state_q == ST_FETCH) && (issue_q != count_q) && (pending < 2'd2);

   // The in-flight word is presented straight from mem_rdata when the buffer
   // is empty; if it is not taken this cycle it is parked in the buffer so
   // the output stays stable after mem_rdata goes away.
   assign out_valid = !buf_empty || inflight_q;
   assign out_data  = !buf_empty ? head_data : (inflight_q ? mem_rdata : '0);
   assign out_index = !buf_empty ? head_idx  : (inflight_q ? fl_idx_q  : '0);
   assign hs        = out_valid && out_ready;
   assign push      = inflight_q && !(buf_empty && out_ready);
   assign pop       = !buf_empty && out_ready;

   assign mem_en   = issue;
   assign mem_addr = base_q + issue_q[AWIDTH-1:0];
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

   assign inflight_d = issue;
   assign fl_idx_d   = issue ? issue_q[AWIDTH-1:0] : fl_idx_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      issue_d = issue_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               count_d = word_count;
               issue_d = '0;
               state_d = (word_count == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               issue_d = issue_nxt;
               if (issue_nxt == count_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (hs && (pending == 2'd1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         issue_q    <= '0;
         inflight_q <= 1'b0;
         fl_idx_q   <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         issue_q    <= issue_d;
         inflight_q <= inflight_d;
         fl_idx_q   <= fl_idx_d;
      end
   end

   rom_seq_fifo2 #(.WIDTH(DWIDTH + AWIDTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .pop_i  (pop),
      .din_i  ({fl_idx_q, mem_rdata}),
      .dout_o (buf_dout),
      .occ_o  (occ)
   );

`ifdef ROM_SEQ_CHECKSUM_EN
   logic [DWIDTH-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (start_acc)  sum_d = '0;
      else if (hs)    sum_d = sum_q + out_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign checksum = sum_q;
`endif

endmodule
